// File: rtl/frame_tx_controller.sv
// frame_tx_controller
//
// Streams a block of bytes from a synchronous-read buffer out of an 8N1 UART
// serializer. The byte sequence is: optional SYNC_BYTE header, payload bytes
// from buffer addresses 0..len-1, then an optional 8-bit additive checksum of
// the payload. After the last stop bit the block stays busy for GAP_CYCLES
// cycles before it returns to IDLE.
//
// Ports
//   clk          system clock
//   rst          asynchronous, active-high reset
//   tx_start     frame request, only sampled in IDLE
//   tx_len       payload length (0 = ignore request, clamped to 2^ADDR_W)
//   tx_abort     finish the byte currently on the line, then skip to the gap
//   rd_data      buffer read data, valid one cycle after rd_adress
//   rd_adress    buffer read address (0 whenever idle)
//   UART_TxD     serial line, idle high
//   tx_busy      high from frame start until the end of the guard interval
//   tx_complete  one-cycle pulse when the frame ends
//   tx_aborted   last frame was aborted; held until the next accepted start
//   state_dbg    current FSM state (IDLE=0, FETCH=1, SHIFT=2, GAP=3)
//
// Request handshake: a request is taken in any cycle where the FSM is IDLE,
// tx_start is 1 and tx_len is non-zero; tx_busy then rises on the next cycle
// and stays high until the end of the frame, and tx_start is ignored while
// tx_busy is high. tx_complete marks the first cycle back in IDLE.
//
// DIV = CLK_HZ/BAUD must be an integer of at least 2; GAP_CYCLES must be >= 1.

module frame_tx_controller #(
  parameter int         ADDR_W      = 9,
  parameter int         CLK_HZ      = 10000000,
  parameter int         BAUD        = 500000,
  parameter bit         HEADER_EN   = 1'b1,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter bit         CHECKSUM_EN = 1'b1,
  parameter int         GAP_CYCLES  = 200000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tx_start,
  input  logic [ADDR_W:0]   tx_len,
  input  logic              tx_abort,
  input  logic [7:0]        rd_data,
  output logic [ADDR_W-1:0] rd_adress,
  output logic              UART_TxD,
  output logic              tx_busy,
  output logic              tx_complete,
  output logic              tx_aborted,
  output logic [1:0]        state_dbg
);

  localparam int DIV   = CLK_HZ / BAUD;
  localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYCLES - 1);
  localparam logic [ADDR_W:0]   MAX_LEN  = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_SHIFT, S_GAP} state_t;
  // Which kind of byte is currently in the shift register.
  typedef enum logic [1:0] {K_HDR, K_PAY, K_CSUM} kind_t;

  state_t            state, state_d;
  kind_t             kind, kind_d;
  logic [7:0]        sh, sh_d;
  logic [DIV_W-1:0]  div_cnt, div_d;
  logic [3:0]        bit_cnt, bit_d;
  logic [GAP_W-1:0]  gap_cnt, gap_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   loaded_cnt, loaded_d;
  logic [7:0]        csum, csum_d;
  logic              abort_pend, abort_pend_d;
  logic [ADDR_W-1:0] addr_d;
  logic              txd_d, busy_d, complete_d, aborted_d;
  logic              load_pay;

  assign state_dbg = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      kind        <= K_HDR;
      sh          <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      len_q       <= '0;
      loaded_cnt  <= '0;
      csum        <= '0;
      abort_pend  <= 1'b0;
      rd_adress   <= '0;
      UART_TxD    <= 1'b1;
      tx_busy     <= 1'b0;
      tx_complete <= 1'b0;
      tx_aborted  <= 1'b0;
    end else begin
      state       <= state_d;
      kind        <= kind_d;
      sh          <= sh_d;
      div_cnt     <= div_d;
      bit_cnt     <= bit_d;
      gap_cnt     <= gap_d;
      len_q       <= len_d;
      loaded_cnt  <= loaded_d;
      csum        <= csum_d;
      abort_pend  <= abort_pend_d;
      rd_adress   <= addr_d;
      UART_TxD    <= txd_d;
      tx_busy     <= busy_d;
      tx_complete <= complete_d;
      tx_aborted  <= aborted_d;
    end
  end

  always_comb begin
    state_d      = state;
    kind_d       = kind;
    sh_d         = sh;
    div_d        = div_cnt;
    bit_d        = bit_cnt;
    gap_d        = gap_cnt;
    len_d        = len_q;
    loaded_d     = loaded_cnt;
    csum_d       = csum;
    abort_pend_d = abort_pend;
    addr_d       = rd_adress;
    txd_d        = UART_TxD;
    busy_d       = tx_busy;
    complete_d   = 1'b0;
    aborted_d    = tx_aborted;
    load_pay     = 1'b0;

    case (state)
      S_IDLE: begin
        if (tx_start && (tx_len != '0)) begin
          len_d        = (tx_len > MAX_LEN) ? MAX_LEN : tx_len;
          loaded_d     = '0;
          csum_d       = '0;
          abort_pend_d = 1'b0;
          aborted_d    = 1'b0;
          busy_d       = 1'b1;
          if (HEADER_EN) begin
            // Header needs no buffer read, so its start bit goes out at once
            // while payload byte 0 is read from address 0 in the background.
            sh_d    = SYNC_BYTE;
            kind_d  = K_HDR;
            txd_d   = 1'b0;
            div_d   = '0;
            bit_d   = '0;
            state_d = S_SHIFT;
          end else begin
            state_d = S_FETCH;
          end
        end
      end

      S_FETCH: load_pay = 1'b1;

      S_SHIFT: begin
        if (tx_abort) abort_pend_d = 1'b1;
        if (div_cnt != DIV_LAST) begin
          div_d = div_cnt + 1'b1;
        end else begin
          div_d = '0;
          if (bit_cnt != 4'd9) begin
            // bit_cnt 0 = start, 1..8 = data LSB first, 9 = stop
            bit_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd8) begin
              txd_d = 1'b1;
            end else begin
              txd_d = sh[0];
              sh_d  = {1'b0, sh[7:1]};
            end
          end else if (tx_abort || abort_pend) begin
            aborted_d = 1'b1;
            gap_d     = GAP_LAST;
            state_d   = S_GAP;
          end else if ((kind == K_HDR) || ((kind == K_PAY) && (loaded_cnt < len_q))) begin
            // Next payload byte was prefetched during this byte.
            load_pay = 1'b1;
          end else if ((kind == K_PAY) && CHECKSUM_EN) begin
            sh_d   = csum;
            kind_d = K_CSUM;
            txd_d  = 1'b0;
            bit_d  = '0;
          end else begin
            gap_d   = GAP_LAST;
            state_d = S_GAP;
          end
        end
      end

      S_GAP: begin
        if (gap_cnt == '0) begin
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          complete_d = 1'b1;
          addr_d     = '0;
        end else begin
          gap_d = gap_cnt - 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (load_pay) begin
      sh_d     = rd_data;
      csum_d   = csum + rd_data;
      loaded_d = loaded_cnt + 1'b1;
      kind_d   = K_PAY;
      txd_d    = 1'b0;
      div_d    = '0;
      bit_d    = '0;
      state_d  = S_SHIFT;
      // Advance only while another payload byte remains, so a full-size frame
      // parks on the top address instead of wrapping to 0 mid-frame.
      if ((loaded_cnt + 1'b1) < len_q) addr_d = rd_adress + 1'b1;
    end
  end

endmodule

// File: tb/tb_frame_tx_controller.sv
module tb_frame_tx_controller;

  localparam int GAP    = 50;
  localparam int DIV_A  = 10000000 / 500000;   // header + checksum instance
  localparam int DIV_B  = 10000000 / 5000000;  // bare payload instance
  localparam int NMEM   = 512;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // ---------------- stimulus signals ----------------
  logic       sel;        // 0: instance A, 1: instance B
  logic       tx_start, tx_abort;
  logic [9:0] tx_len;
  logic [7:0] mem [NMEM];

  logic       start_a, start_b, abort_a, abort_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic [8:0] addr_a, addr_b;
  logic       txd_a, txd_b, busy_a, busy_b, cmp_a, cmp_b, abt_a, abt_b;
  logic [1:0] st_a, st_b;

  assign start_a = tx_start & ~sel;
  assign start_b = tx_start &  sel;
  assign abort_a = tx_abort & ~sel;
  assign abort_b = tx_abort &  sel;

  always @(posedge clk) begin
    rd_data_a <= mem[addr_a];
    rd_data_b <= mem[addr_b];
  end

  frame_tx_controller #(
    .ADDR_W(9), .CLK_HZ(10000000), .BAUD(500000), .HEADER_EN(1'b1),
    .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b1), .GAP_CYCLES(GAP)
  ) dut_a (
    .clk(clk), .rst(rst), .tx_start(start_a), .tx_len(tx_len), .tx_abort(abort_a),
    .rd_data(rd_data_a), .rd_adress(addr_a), .UART_TxD(txd_a), .tx_busy(busy_a),
    .tx_complete(cmp_a), .tx_aborted(abt_a), .state_dbg(st_a)
  );

  frame_tx_controller #(
    .ADDR_W(9), .CLK_HZ(10000000), .BAUD(5000000), .HEADER_EN(1'b0),
    .SYNC_BYTE(8'hA5), .CHECKSUM_EN(1'b0), .GAP_CYCLES(GAP)
  ) dut_b (
    .clk(clk), .rst(rst), .tx_start(start_b), .tx_len(tx_len), .tx_abort(abort_b),
    .rd_data(rd_data_b), .rd_adress(addr_b), .UART_TxD(txd_b), .tx_busy(busy_b),
    .tx_complete(cmp_b), .tx_aborted(abt_b), .state_dbg(st_b)
  );

  logic       txd, busy, cmp, abt;
  logic [8:0] addr;
  assign txd  = sel ? txd_b  : txd_a;
  assign busy = sel ? busy_b : busy_a;
  assign cmp  = sel ? cmp_b  : cmp_a;
  assign abt  = sel ? abt_b  : abt_a;
  assign addr = sel ? addr_b : addr_a;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) mem[i] = 8'($urandom_range(0, 255));
  endtask

  // Runs one frame on the selected instance and compares every cycle against
  // a waveform built from the byte list: header, payload, checksum, each as
  // start/8 data LSB-first/stop, DIV cycles per bit, then a GAP-cycle guard.
  task automatic run_frame(input int len, input int abort_byte, input bit ign_start,
                           input bit abort_in_gap);
    logic [7:0] exp_q[$];
    logic [7:0] sum, b8;
    int div, s0, eff, nb, last, rel, bi, bit_i, t_abort;
    int line_err, busy_err, n_cmp, cmp_t, addr_max, addr_back, prev_addr;
    bit hdr, csum_en, exp_abort;
    logic e;

    div     = sel ? DIV_B : DIV_A;
    hdr     = !sel;
    csum_en = !sel;
    eff     = (len > NMEM) ? NMEM : len;
    sum     = 8'h00;
    exp_q.delete();
    if (hdr) exp_q.push_back(8'hA5);
    for (int i = 0; i < eff; i++) begin
      exp_q.push_back(mem[i]);
      sum = sum + mem[i];
    end
    if (csum_en) exp_q.push_back(sum);
    exp_abort = 1'b0;
    if (abort_byte >= 0) begin
      exp_abort = 1'b1;
      while (exp_q.size() > abort_byte + 1) void'(exp_q.pop_back());
    end
    nb      = exp_q.size();
    s0      = hdr ? 1 : 2;
    last    = s0 + nb * 10 * div - 1 + GAP;
    t_abort = s0 + abort_byte * 10 * div + 5 * div;

    line_err = 0; busy_err = 0; n_cmp = 0; cmp_t = -1;
    addr_max = 0; addr_back = 0; prev_addr = 0;

    @(negedge clk);
    tx_start = 1'b1;
    tx_len   = 10'(len);
    @(negedge clk);
    tx_start = 1'b0;
    for (int t = 1; t <= last + 3; t++) begin
      rel = t - s0;
      e   = 1'b1;
      if (rel >= 0 && rel < nb * 10 * div) begin
        bi    = rel / (10 * div);
        bit_i = (rel % (10 * div)) / div;
        b8    = exp_q[bi];
        if (bit_i == 0) e = 1'b0;
        else if (bit_i != 9) e = b8[bit_i-1];
      end
      if (txd !== e) line_err++;
      if (busy !== (t <= last)) busy_err++;
      if (cmp === 1'b1) begin
        n_cmp++;
        cmp_t = t;
      end
      if (t == 1) check("aborted_clr_on_start", abt, 0);
      if (t <= last) begin
        if (int'(addr) < prev_addr) addr_back++;
        if (int'(addr) > addr_max) addr_max = int'(addr);
        prev_addr = int'(addr);
      end
      if (t == last + 1) begin
        check("aborted_at_complete", abt, exp_abort);
        check("addr_idle_zero", addr, 0);
      end
      tx_abort = (abort_byte >= 0 && t == t_abort) || (abort_in_gap && t == last - 5);
      tx_start = ign_start && (t == s0 + 5 || t == last - 10);
      @(negedge clk);
    end
    tx_abort = 1'b0;
    tx_start = 1'b0;
    check("line_wave", line_err, 0);
    check("busy_wave", busy_err, 0);
    check("complete_count", n_cmp, 1);
    check("complete_time", cmp_t, last + 1);
    check("addr_no_wrap", addr_back, 0);
    if (!exp_abort) check("addr_max", addr_max, eff - 1);
  endtask

  // ---------------- main sequence ----------------
  int quiet_busy, quiet_low, quiet_cmp, rl;

  initial begin
    rst = 1'b1; sel = 1'b0; tx_start = 1'b0; tx_abort = 1'b0; tx_len = '0;
    for (int i = 0; i < NMEM; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);

    // reset values on both instances
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check("rst_txd", txd, 1);
      check("rst_busy", busy, 0);
      check("rst_complete", cmp, 0);
      check("rst_aborted", abt, 0);
      check("rst_addr", addr, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal frame: A5 01 02 03 04 0A
    sel = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'(i + 1);
    run_frame(4, -1, 0, 0);

    // checksum wrap FF FF 03 -> 01, with and without header/checksum
    mem[0] = 8'hFF; mem[1] = 8'hFF; mem[2] = 8'h03;
    run_frame(3, -1, 0, 0);
    sel = 1'b1;
    run_frame(3, -1, 0, 0);

    // zero length: no activity
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      quiet_busy = 0; quiet_low = 0; quiet_cmp = 0;
      @(negedge clk);
      tx_start = 1'b1; tx_len = 10'd0;
      @(negedge clk);
      tx_start = 1'b0;
      for (int t = 0; t < 30; t++) begin
        if (busy !== 1'b0) quiet_busy++;
        if (txd !== 1'b1) quiet_low++;
        if (cmp !== 1'b0) quiet_cmp++;
        @(negedge clk);
      end
      check("len0_busy", quiet_busy, 0);
      check("len0_line", quiet_low, 0);
      check("len0_complete", quiet_cmp, 0);
    end

    // clamp 1023 -> 512 bytes
    sel = 1'b1;
    fill_random(NMEM);
    run_frame(1023, -1, 0, 0);

    // abort during payload byte 2 (line byte 3); abort in GAP has no effect
    sel = 1'b0;
    fill_random(8);
    run_frame(6, 3, 0, 1);
    run_frame(2, -1, 0, 0);

    // starts during SHIFT and GAP ignored
    run_frame(3, -1, 1, 0);
    sel = 1'b1;
    run_frame(4, -1, 1, 0);

    // reset in the start bit of byte 3
    sel = 1'b0;
    fill_random(6);
    @(negedge clk);
    tx_start = 1'b1; tx_len = 10'd6;
    @(negedge clk);
    tx_start = 1'b0;
    repeat (3 * 10 * DIV_A) @(negedge clk);
    check("pre_rst_start_bit", txd, 0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_txd", txd, 1);
    check("async_rst_busy", busy, 0);
    quiet_cmp = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (t == 5) rst = 1'b0;
      if (cmp !== 1'b0) quiet_cmp++;
    end
    check("rst_no_complete", quiet_cmp, 0);
    run_frame(6, -1, 0, 0);

    // randomized frames on both instances
    for (int k = 0; k < 6; k++) begin
      sel = k[0];
      rl  = $urandom_range(1, 8);
      fill_random(rl);
      if ($urandom_range(0, 2) == 0) run_frame(rl, $urandom_range(0, rl - 1), 1'($urandom_range(0, 1)), 0);
      else run_frame(rl, -1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
